// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: launches a program run, issues fetched instructions,
// resolves backward branches through a 16-entry offset LUT and stops on HALT.
module fetch_sequencer #(
    parameter int PC_BITS    = 12,
    parameter int INSTR_BITS = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [PC_BITS-1:0]    pc,
    input  logic                  cond_true,
    input  logic [INSTR_BITS-1:0] imem_data,
    input  logic                  lut_we,
    input  logic [3:0]            lut_waddr,
    input  logic [7:0]            lut_wdata,
    output logic [PC_BITS-1:0]    imem_addr,
    output logic                  pc_start,
    output logic                  jumpFlag,
    output logic [7:0]            target,
    output logic [INSTR_BITS-1:0] instr,
    output logic [PC_BITS-1:0]    instr_pc,
    output logic                  instr_valid,
    output logic                  done,
    output logic [15:0]           instr_count
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LAUNCH = 3'd1;
    localparam logic [2:0] FILL   = 3'd2;
    localparam logic [2:0] RUN    = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]         state_r;
    logic [2:0]         state_next_s;
    logic               squash_r;
    logic               done_r;
    logic [15:0]        count_r;
    logic [PC_BITS-1:0] instr_pc_r;
    logic [7:0]         lut_r [16];

    logic               valid_s;
    logic               halt_s;
    logic               branch_s;
    logic               jump_s;
    logic               launch_req_s;
    logic [7:0]         target_s;

    assign imem_addr   = pc;
    assign instr       = imem_data;
    assign instr_pc    = instr_pc_r;
    assign instr_valid = valid_s;
    assign jumpFlag    = jump_s;
    assign target      = target_s;
    assign pc_start    = (state_r == LAUNCH);
    assign done        = done_r;
    assign instr_count = count_r;

    // Decode of the issued slot; the slot right after a taken branch is dropped.
    always_comb begin
        valid_s      = (state_r == RUN) && !squash_r;
        halt_s       = &imem_data;
        branch_s     = (imem_data[8:6] == 3'b110) && !halt_s;
        jump_s       = valid_s && branch_s && cond_true;
        launch_req_s = ((state_r == IDLE) || (state_r == DONE)) && start;
        if (jump_s) begin
            target_s = lut_r[imem_data[3:0]];
        end else begin
            target_s = 8'd0;
        end
    end

    // Next-state logic of the run controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_next_s = LAUNCH;
                end else begin
                    state_next_s = state_r;
                end
            end
            LAUNCH:  state_next_s = FILL;
            FILL:    state_next_s = RUN;
            RUN: begin
                if (valid_s && halt_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Controller state, squash flag, completion flag and retire counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            squash_r   <= 1'b0;
            done_r     <= 1'b0;
            count_r    <= 16'd0;
            instr_pc_r <= {PC_BITS{1'b0}};
        end else begin
            state_r    <= state_next_s;
            squash_r   <= jump_s;
            instr_pc_r <= pc;
            if (launch_req_s) begin
                done_r <= 1'b0;
            end else if (valid_s && halt_s) begin
                done_r <= 1'b1;
            end else begin
                done_r <= done_r;
            end
            if (state_r == LAUNCH) begin
                count_r <= 16'd0;
            end else if (valid_s && (count_r != 16'hFFFF)) begin
                count_r <= count_r + 16'd1;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Branch-offset table; a same-cycle read sees the pre-write contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                lut_r[i] <= 8'd0;
            end
        end else if (lut_we) begin
            lut_r[lut_waddr] <= lut_wdata;
        end else begin
            lut_r[lut_waddr] <= lut_r[lut_waddr];
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural program counter and
// a registered instruction memory around the DUT.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [11:0] pc;
    logic        cond_true = 1'b0;
    logic [8:0]  imem_data;
    logic        lut_we = 1'b0;
    logic [3:0]  lut_waddr = 4'd0;
    logic [7:0]  lut_wdata = 8'd0;
    logic [11:0] imem_addr;
    logic        pc_start;
    logic        jumpFlag;
    logic [7:0]  target;
    logic [8:0]  instr;
    logic [11:0] instr_pc;
    logic        instr_valid;
    logic        done;
    logic [15:0] instr_count;

    logic [8:0]  mem [4096];
    int          checks = 0;
    int          errors = 0;

    fetch_sequencer #(.PC_BITS(12), .INSTR_BITS(9)) dut (
        .clock(clock), .reset(reset), .start(start), .pc(pc),
        .cond_true(cond_true), .imem_data(imem_data), .lut_we(lut_we),
        .lut_waddr(lut_waddr), .lut_wdata(lut_wdata), .imem_addr(imem_addr),
        .pc_start(pc_start), .jumpFlag(jumpFlag), .target(target),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .done(done), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    // Program counter model: start clears, jump subtracts target, else increments.
    always @(posedge clock) begin
        if (reset || pc_start) pc <= 12'd0;
        else if (jumpFlag)     pc <= pc - {4'd0, target};
        else                   pc <= pc + 12'd1;
    end

    always @(posedge clock) imem_data <= mem[imem_addr];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 9'h000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic write_lut(input logic [3:0] a, input logic [7:0] d);
        lut_we = 1'b1; lut_waddr = a; lut_wdata = d;
        tick();
        lut_we = 1'b0;
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
    endtask

    task automatic run_to(input int addr);
        int n;
        n = 0;
        while (!(instr_valid && (int'(instr_pc) == addr)) && (n < 200)) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL run_to: valid slot at instr_pc %0d not seen within 200 cycles", addr);
        end
    endtask

    task automatic test_reset();
        start = 1'b1; lut_we = 1'b1; lut_waddr = 4'd0; lut_wdata = 8'hAA;
        reset = 1'b1;
        tick();
        tick();
        start = 1'b0; lut_we = 1'b0;
        checks++;
        if ({pc_start, jumpFlag, instr_valid, done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {pc_start, jumpFlag, instr_valid, done});
        end
        checks++;
        if (target !== 8'd0 || instr_count !== 16'd0 || instr_pc !== 12'd0) begin
            errors++;
            $display("FAIL reset_values: target=%0d count=%0d instr_pc=%0d expected 0/0/0",
                     target, instr_count, instr_pc);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (pc_start !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: pc_start=%b instr_valid=%b expected 0/0", pc_start, instr_valid);
        end
    endtask

    task automatic test_launch();
        clear_mem();
        mem[0] = 9'h015;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (pc_start !== 1'b1) begin
            errors++;
            $display("FAIL launch_pc_start: got %b expected 1", pc_start);
        end
        tick();
        checks++;
        if (pc_start !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL fill_cycle: pc_start=%b instr_valid=%b expected 0/0", pc_start, instr_valid);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 12'd0 || instr !== 9'h015) begin
            errors++;
            $display("FAIL first_issue: valid=%b instr_pc=%0d instr=%h expected 1/0/015",
                     instr_valid, instr_pc, instr);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (pc_start !== 1'b0 || instr_pc !== 12'd1 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored_in_run: pc_start=%b instr_pc=%0d valid=%b expected 0/1/1",
                     pc_start, instr_pc, instr_valid);
        end
    endtask

    task automatic test_branch_taken();
        clear_mem();
        mem[10] = 9'h182;
        do_reset();
        write_lut(4'd2, 8'd5);
        cond_true = 1'b1;
        launch();
        run_to(10);
        lut_we = 1'b1; lut_waddr = 4'd2; lut_wdata = 8'd9;
        checks++;
        if (jumpFlag !== 1'b1 || target !== 8'd5) begin
            errors++;
            $display("FAIL branch_taken: jumpFlag=%b target=%0d expected 1/5 (old LUT value)", jumpFlag, target);
        end
        tick();
        lut_we = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || instr_pc !== 12'd11 || jumpFlag !== 1'b0) begin
            errors++;
            $display("FAIL branch_squash: valid=%b instr_pc=%0d jumpFlag=%b expected 0/11/0",
                     instr_valid, instr_pc, jumpFlag);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 12'd6) begin
            errors++;
            $display("FAIL branch_target: valid=%b instr_pc=%0d expected 1/6", instr_valid, instr_pc);
        end
        run_to(10);
        checks++;
        if (jumpFlag !== 1'b1 || target !== 8'd9) begin
            errors++;
            $display("FAIL branch_new_lut: jumpFlag=%b target=%0d expected 1/9", jumpFlag, target);
        end
    endtask

    task automatic test_branch_not_taken();
        clear_mem();
        mem[10] = 9'h182;
        do_reset();
        write_lut(4'd2, 8'd5);
        cond_true = 1'b0;
        launch();
        run_to(10);
        checks++;
        if (jumpFlag !== 1'b0 || target !== 8'd0) begin
            errors++;
            $display("FAIL not_taken: jumpFlag=%b target=%0d expected 0/0", jumpFlag, target);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 12'd11) begin
            errors++;
            $display("FAIL not_taken_next: valid=%b instr_pc=%0d expected 1/11", instr_valid, instr_pc);
        end
    endtask

    task automatic test_zero_target();
        clear_mem();
        mem[10] = 9'h183;
        do_reset();
        cond_true = 1'b1;
        launch();
        run_to(10);
        checks++;
        if (jumpFlag !== 1'b1 || target !== 8'd0) begin
            errors++;
            $display("FAIL zero_target: jumpFlag=%b target=%0d expected 1/0", jumpFlag, target);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0 || instr_pc !== 12'd11) begin
            errors++;
            $display("FAIL zero_target_squash: valid=%b instr_pc=%0d expected 0/11", instr_valid, instr_pc);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 12'd11) begin
            errors++;
            $display("FAIL zero_target_refetch: valid=%b instr_pc=%0d expected 1/11", instr_valid, instr_pc);
        end
        cond_true = 1'b0;
    endtask

    task automatic test_halt();
        clear_mem();
        mem[4] = 9'h1FF;
        do_reset();
        launch();
        run_to(4);
        tick();
        checks++;
        if (done !== 1'b1 || instr_count !== 16'd5 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt: done=%b count=%0d valid=%b expected 1/5/0", done, instr_count, instr_valid);
        end
        tick();
        checks++;
        if (done !== 1'b1 || instr_valid !== 1'b0 || instr_count !== 16'd5) begin
            errors++;
            $display("FAIL halt_hold: done=%b valid=%b count=%0d expected 1/0/5", done, instr_valid, instr_count);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (pc_start !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart: pc_start=%b done=%b expected 1/0", pc_start, done);
        end
        tick();
        checks++;
        if (instr_count !== 16'd0) begin
            errors++;
            $display("FAIL restart_count: got %0d expected 0", instr_count);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 12'd0) begin
            errors++;
            $display("FAIL restart_issue: valid=%b instr_pc=%0d expected 1/0", instr_valid, instr_pc);
        end
    endtask

    task automatic test_squashed_halt_and_abort();
        clear_mem();
        mem[5] = 9'h181;
        mem[6] = 9'h1FF;
        do_reset();
        write_lut(4'd1, 8'd3);
        cond_true = 1'b1;
        launch();
        run_to(5);
        tick();
        checks++;
        if (instr !== 9'h1FF || instr_valid !== 1'b0 || instr_pc !== 12'd6) begin
            errors++;
            $display("FAIL squashed_halt_slot: instr=%h valid=%b instr_pc=%0d expected 1ff/0/6",
                     instr, instr_valid, instr_pc);
        end
        tick();
        checks++;
        if (done !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 12'd3) begin
            errors++;
            $display("FAIL squashed_halt_ignored: done=%b valid=%b instr_pc=%0d expected 0/1/3",
                     done, instr_valid, instr_pc);
        end
        run_to(5);
        reset = 1'b1;
        tick();
        checks++;
        if ({pc_start, jumpFlag, instr_valid, done} !== 4'b0000 || target !== 8'd0 ||
            instr_count !== 16'd0 || instr_pc !== 12'd0) begin
            errors++;
            $display("FAIL abort: flags=%b target=%0d count=%0d instr_pc=%0d expected 0000/0/0/0",
                     {pc_start, jumpFlag, instr_valid, done}, target, instr_count, instr_pc);
        end
        reset = 1'b0;
        launch();
        run_to(5);
        checks++;
        if (jumpFlag !== 1'b1 || target !== 8'd0) begin
            errors++;
            $display("FAIL abort_lut_cleared: jumpFlag=%b target=%0d expected 1/0", jumpFlag, target);
        end
        cond_true = 1'b0;
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_launch();
        test_branch_taken();
        test_branch_not_taken();
        test_zero_target();
        test_halt();
        test_squashed_halt_and_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
